// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: instruction/PC constants, the fetch state
// enum and the IF/ID payload layout. The PC register reads the same constants.
package cpu_pkg;

   localparam int unsigned XLEN         = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] RESET_PC     = 32'h0040_0000;
   localparam logic [31:0] PC_LIMIT     = 32'h0040_0060;
   localparam int unsigned DRAIN_CYCLES = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   // One IF/ID pipeline entry as seen by decode
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with reset > bubble > stall > load priority.
// Ports: clk, reset (sync, active-low), bubble (insert NOP), stall (hold),
//        pc_in/pc_plus4_in/instr_in (load data), pc/pc_plus4/instr/valid (entry).
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VAL = cpu_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            bubble,
   input  logic            stall,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pc_plus4_in,
   input  logic [XLEN-1:0] instr_in,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] instr,
   output logic            valid
);

   if_id_t entry_q;
   if_id_t entry_d;

   // A bubble keeps the PC fields so decode still sees where the hole sits
   always_comb begin
      entry_d = entry_q;
      if (bubble) begin
         entry_d.instr = NOP_INSTR;
         entry_d.valid = 1'b0;
      end else if (!stall) begin
         entry_d.pc       = pc_in;
         entry_d.pc_plus4 = pc_plus4_in;
         entry_d.instr    = instr_in;
         entry_d.valid    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         entry_q.pc       <= RESET_VAL;
         entry_q.pc_plus4 <= RESET_VAL + XLEN'(4);
         entry_q.instr    <= NOP_INSTR;
         entry_q.valid    <= 1'b0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign pc       = entry_q.pc;
   assign pc_plus4 = entry_q.pc_plus4;
   assign instr    = entry_q.instr;
   assign valid    = entry_q.valid;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage glue: next-PC/keep generation for the PC register, IF/ID
// register control, and end-of-image drain/halt sequencing.
// Ports: clk, reset (sync, active-low), pc_if/instr_if (fetch), stall/flush/
//        branch_target (hazard/branch), pc_next/pc_keep (comb, to PC register),
//        id_pc/id_pc_plus4/id_instr/id_valid (IF/ID), halted.
module if_id_stage
   import cpu_pkg::XLEN;
   import cpu_pkg::fetch_state_e;
   import cpu_pkg::RUN;
   import cpu_pkg::DRAIN;
   import cpu_pkg::HALT;
#(
   parameter logic [31:0] RESET_PC     = cpu_pkg::RESET_PC,
   parameter logic [31:0] PC_LIMIT     = cpu_pkg::PC_LIMIT,
   parameter int unsigned DRAIN_CYCLES = cpu_pkg::DRAIN_CYCLES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_if,
   input  logic [XLEN-1:0] instr_if,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] pc_next,
   output logic            pc_keep,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [XLEN-1:0] id_instr,
   output logic            id_valid,
   output logic            halted
);

   localparam int unsigned     CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   fetch_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_q, halted_d;

   logic             flush_eff_c;
   logic             go_drain_c;
   logic             bubble_c;
   logic [XLEN-1:0]  pc_plus4_c;

   // Next-state, drain counter and IF/ID control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flush_eff_c = flush & (state_q != HALT);
      pc_plus4_c  = pc_if + XLEN'(4);
      go_drain_c  = (state_q == RUN) & (pc_if >= PC_LIMIT) & ~stall & ~flush;
      // Leaving RUN or sitting outside it always feeds decode a bubble
      bubble_c    = flush_eff_c | (state_q != RUN) | go_drain_c;

      case (state_q)
         RUN: begin
            if (go_drain_c) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            // A branch still in ID can pull fetch back into the program
            if (flush) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               if (cnt_q == CNT_LAST) state_d = HALT;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase

      halted_d = (state_d == HALT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   // Feeds the PC register directly; no register in between
   assign pc_next = flush_eff_c ? branch_target : pc_plus4_c;
   assign pc_keep = ~flush_eff_c & (stall | (state_q != RUN));
   assign halted  = halted_q;

   if_id_reg #(
      .RESET_VAL (RESET_PC)
   ) u_if_id_reg (
      .clk         (clk),
      .reset       (reset),
      .bubble      (bubble_c),
      .stall       (stall),
      .pc_in       (pc_if),
      .pc_plus4_in (pc_plus4_c),
      .instr_in    (instr_if),
      .pc          (id_pc),
      .pc_plus4    (id_pc_plus4),
      .instr       (id_instr),
      .valid       (id_valid)
   );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: fixed vector table, directed drain/reset sequences,
// then random stimulus against a behavioural model.
module tb_if_id_stage;

   localparam logic [31:0] RPC = 32'h0040_0000;
   localparam logic [31:0] LIM = 32'h0040_0060;
   localparam int          DC  = 4;

   logic        clk, reset, stall, flush;
   logic [31:0] pc_if, instr_if, branch_target;
   logic [31:0] pc_next, id_pc, id_pc_plus4, id_instr;
   logic        pc_keep, id_valid, halted;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: mode 0=running, 1=draining, 2=halted
   int          m_mode = 0;
   int          m_age  = 0;
   logic [31:0] m_pc = RPC, m_pc4 = RPC + 32'd4, m_instr = 32'd0;
   logic        m_valid = 1'b0, m_halt = 1'b0;

   // Comb outputs captured before the edge, and the model's view of them
   logic [31:0] c_next, e_next;
   logic        c_keep, e_keep;

   typedef struct {
      logic        rst_n;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        stall;
      logic        flush;
      logic [31:0] tgt;
      logic        chk_comb;
      logic [31:0] x_next;
      logic        x_keep;
      logic [31:0] x_pc;
      logic [31:0] x_pc4;
      logic [31:0] x_instr;
      logic        x_valid;
      logic        x_halted;
   } vec_t;

   vec_t tbl[16];

   if_id_stage #(
      .RESET_PC     (RPC),
      .PC_LIMIT     (LIM),
      .DRAIN_CYCLES (DC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_if         (pc_if),
      .instr_if      (instr_if),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .pc_next       (pc_next),
      .pc_keep       (pc_keep),
      .id_pc         (id_pc),
      .id_pc_plus4   (id_pc_plus4),
      .id_instr      (id_instr),
      .id_valid      (id_valid),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Spec rules applied to one clock edge
   task automatic model_edge(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                             input logic st, input logic fl, input logic [31:0] tgt);
      if (!r) begin
         m_mode = 0; m_age = 0;
         m_pc = RPC; m_pc4 = RPC + 32'd4; m_instr = 32'd0; m_valid = 1'b0;
      end else if (fl && m_mode != 2) begin
         m_instr = 32'd0; m_valid = 1'b0;
         m_mode = 0; m_age = 0;
      end else if (m_mode != 0) begin
         m_instr = 32'd0; m_valid = 1'b0;
         if (m_mode == 1) begin
            m_age++;
            if (m_age >= DC) m_mode = 2;
         end
      end else if (st) begin
         // hold
      end else if (pc >= LIM) begin
         m_instr = 32'd0; m_valid = 1'b0;
         m_mode = 1; m_age = 0;
      end else begin
         m_pc = pc; m_pc4 = pc + 32'd4; m_instr = ins; m_valid = 1'b1;
      end
      m_halt = (m_mode == 2);
   endtask

   // Drive one cycle: apply inputs, capture comb outputs, clock, update model
   task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic fl, input logic [31:0] tgt);
      logic fe;
      reset = r; pc_if = pc; instr_if = ins; stall = st; flush = fl; branch_target = tgt;
      #1;
      c_next = pc_next;
      c_keep = pc_keep;
      fe     = fl && (m_mode != 2);
      e_next = fe ? tgt : pc + 32'd4;
      e_keep = !fe && (st || m_mode != 0);
      @(posedge clk);
      model_edge(r, pc, ins, st, fl, tgt);
      #1;
   endtask

   task automatic chk_model(input string tag, input logic with_comb);
      if (with_comb) begin
         chk({tag, ".pc_next"}, c_next, e_next);
         chk({tag, ".pc_keep"}, 32'(c_keep), 32'(e_keep));
      end
      chk({tag, ".id_pc"},       id_pc,       m_pc);
      chk({tag, ".id_pc_plus4"}, id_pc_plus4, m_pc4);
      chk({tag, ".id_instr"},    id_instr,    m_instr);
      chk({tag, ".id_valid"},    32'(id_valid), 32'(m_valid));
      chk({tag, ".halted"},      32'(halted),   32'(m_halt));
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      pc_if = RPC; instr_if = 32'd0; branch_target = 32'd0;

      //          rst  pc            instr         st    fl    tgt           cc    next          keep  id_pc         id_pc4        id_instr      v     h
      tbl[0]  = '{1'b0, 32'h00400000, 32'h11111111, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00400000, 32'h00400004, 32'h00000000, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 32'h00400000, 32'h11111111, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00400004, 1'b0, 32'h00400000, 32'h00400004, 32'h00000000, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 32'h00400008, 32'h20080005, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h0040000C, 1'b0, 32'h00400008, 32'h0040000C, 32'h20080005, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 32'h0040000C, 32'hAAAA0001, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00400010, 1'b1, 32'h00400008, 32'h0040000C, 32'h20080005, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 32'h0040000C, 32'hAAAA0002, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00400010, 1'b1, 32'h00400008, 32'h0040000C, 32'h20080005, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 32'h0040000C, 32'hAAAA0003, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00400010, 1'b1, 32'h00400008, 32'h0040000C, 32'h20080005, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 32'h0040000C, 32'hBBBB0000, 1'b1, 1'b1, 32'h00400020, 1'b1, 32'h00400020, 1'b0, 32'h00400008, 32'h0040000C, 32'h00000000, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 32'h00400020, 32'h8C090000, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00400024, 1'b0, 32'h00400020, 32'h00400024, 32'h8C090000, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 32'hFFFFFFFC, 32'hCCCC0000, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 32'h00400020, 32'h00400024, 32'h8C090000, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 32'h0040005C, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00400060, 1'b0, 32'h0040005C, 32'h00400060, 32'h12345678, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 32'h00400060, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00400064, 1'b0, 32'h0040005C, 32'h00400060, 32'h00000000, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 32'h00400060, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00400064, 1'b1, 32'h0040005C, 32'h00400060, 32'h00000000, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 32'h00400060, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00400064, 1'b1, 32'h0040005C, 32'h00400060, 32'h00000000, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 32'h00400060, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00400064, 1'b1, 32'h0040005C, 32'h00400060, 32'h00000000, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 32'h00400060, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00400064, 1'b1, 32'h0040005C, 32'h00400060, 32'h00000000, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 32'h00400060, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00400010, 1'b1, 32'h00400064, 1'b1, 32'h0040005C, 32'h00400060, 32'h00000000, 1'b0, 1'b1};

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rst_n, tbl[i].pc, tbl[i].instr, tbl[i].stall, tbl[i].flush, tbl[i].tgt);
         if (tbl[i].chk_comb) begin
            chk($sformatf("vec%0d.pc_next", i), c_next, tbl[i].x_next);
            chk($sformatf("vec%0d.pc_keep", i), 32'(c_keep), 32'(tbl[i].x_keep));
         end
         chk($sformatf("vec%0d.id_pc", i),       id_pc,         tbl[i].x_pc);
         chk($sformatf("vec%0d.id_pc_plus4", i), id_pc_plus4,   tbl[i].x_pc4);
         chk($sformatf("vec%0d.id_instr", i),    id_instr,      tbl[i].x_instr);
         chk($sformatf("vec%0d.id_valid", i),    32'(id_valid), 32'(tbl[i].x_valid));
         chk($sformatf("vec%0d.halted", i),      32'(halted),   32'(tbl[i].x_halted));
      end

      // Flush one cycle into the drain redirects back into the program
      step(1'b0, RPC, 32'd0, 1'b0, 1'b0, 32'd0);
      step(1'b0, RPC, 32'd0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 32'h00400004, 32'h01010101, 1'b0, 1'b0, 32'd0);
      step(1'b1, 32'h00400060, 32'h02020202, 1'b0, 1'b0, 32'd0);
      step(1'b1, 32'h00400060, 32'h02020202, 1'b0, 1'b0, 32'd0);
      chk_model("drn_pre", 1'b1);
      step(1'b1, 32'h00400060, 32'h02020202, 1'b0, 1'b1, 32'h00400010);
      chk("drn_flush.pc_next", c_next, 32'h00400010);
      chk("drn_flush.pc_keep", 32'(c_keep), 32'd0);
      chk("drn_flush.id_valid", 32'(id_valid), 32'd0);
      chk("drn_flush.id_instr", id_instr, 32'd0);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 32'h00400010 + 32'(4 * k), 32'h30000000 + 32'(k), 1'b0, 1'b0, 32'd0);
         chk($sformatf("drn_run%0d.pc_keep", k), 32'(c_keep), 32'd0);
         chk($sformatf("drn_run%0d.id_valid", k), 32'(id_valid), 32'd1);
         chk($sformatf("drn_run%0d.id_pc", k), id_pc, 32'h00400010 + 32'(4 * k));
         chk($sformatf("drn_run%0d.halted", k), 32'(halted), 32'd0);
      end

      // Reset while halted restores reset values and RUN behaviour
      for (int k = 0; k < 6; k++) step(1'b1, 32'h00400080, 32'h04040404, 1'b0, 1'b0, 32'd0);
      chk("hlt.halted", 32'(halted), 32'd1);
      step(1'b0, 32'h00400080, 32'h04040404, 1'b0, 1'b0, 32'd0);
      chk("hlt_rst.halted", 32'(halted), 32'd0);
      chk("hlt_rst.id_pc", id_pc, 32'h00400000);
      chk("hlt_rst.id_pc_plus4", id_pc_plus4, 32'h00400004);
      chk("hlt_rst.id_valid", 32'(id_valid), 32'd0);
      step(1'b1, 32'h00400000, 32'h05050505, 1'b0, 1'b0, 32'd0);
      chk("hlt_rel.pc_next", c_next, 32'h00400004);
      chk("hlt_rel.pc_keep", 32'(c_keep), 32'd0);
      chk("hlt_rel.id_valid", 32'(id_valid), 32'd1);

      // Random traffic against the model
      for (int k = 0; k < 1500; k++) begin
         logic        r, st, fl;
         logic [31:0] pc, ins, tgt;
         r   = ($urandom_range(0, 39) != 0);
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 5) == 0);
         pc  = ($urandom_range(0, 4) == 0) ? LIM + 32'($urandom_range(0, 64)) * 32'd4
                                           : RPC + 32'($urandom_range(0, 23)) * 32'd4;
         if ($urandom_range(0, 49) == 0) pc = 32'hFFFFFFFC;
         ins = $urandom;
         tgt = RPC + 32'($urandom_range(0, 23)) * 32'd4;
         step(r, pc, ins, st, fl, tgt);
         chk_model($sformatf("rnd%0d", k), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-side companion to the PC register: generates the PC register's next-address and keep inputs, and holds the IF/ID pipeline register (PC, PC+4, instruction, valid) consumed by decode. Applies stall and flush from the hazard/branch logic. Detects the end of the program image, drains the pipeline and reports `halted`.

## Interface
Parameters:
- `RESET_PC`, 32'h00400000, PC value after reset; also the reset value of `id_pc`.
- `PC_LIMIT`, 32'h00400060, first address past the program image; fetch at or above it starts the drain.
- `DRAIN_CYCLES`, 4, bubble cycles after the drain starts before `halted` rises (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of `clk`).
- `pc_if`  in  32  current PC, from the PC register output.
- `instr_if`  in  32  instruction-memory read data at `pc_if` (combinational, same cycle).
- `stall`  in  1  hazard unit: hold the PC and IF/ID.
- `flush`  in  1  branch/jump taken, resolved in ID: redirect and bubble.
- `branch_target`  in  32  redirect address, valid when `flush`=1.
- `pc_next`  out  32  next PC, to the PC register data input.
- `pc_keep`  out  1  PC hold, to the PC register keep input.
- `id_pc`  out  32  IF/ID PC.
- `id_pc_plus4`  out  32  IF/ID PC+4.
- `id_instr`  out  32  IF/ID instruction; NOP (32'h00000000) when invalid.
- `id_valid`  out  1  IF/ID entry holds a real instruction.
- `halted`  out  1  program finished and pipeline drained.

## Operation
- States: RUN, DRAIN, HALT. Reset → RUN.
- `flush_eff` = `flush` & (state≠HALT).
- `pc_next` = `flush_eff` ? `branch_target` : `pc_if`+4, with modulo-2^32 wrap and no clamp. Clamping is the PC register's job.
- `pc_keep` = ~`flush_eff` & (`stall` | state≠RUN).
- IF/ID update, in priority order:
  1. Reset: `id_pc`=`RESET_PC`, `id_pc_plus4`=`RESET_PC`+4, `id_instr`=NOP, `id_valid`=0.
  2. `flush_eff`: `id_instr`=NOP, `id_valid`=0. `id_pc` and `id_pc_plus4` hold. Flush beats stall.
  3. state≠RUN: load a bubble, same as the flush case.
  4. `stall`: hold all four fields.
  5. Otherwise load `pc_if`, `pc_if`+4, `instr_if`, and `id_valid`=1.
- RUN → DRAIN: when `pc_if` ≥ `PC_LIMIT` (unsigned), no `stall`, no `flush`. In that cycle IF/ID loads a bubble, not `instr_if`, and the drain counter clears to 0.
- DRAIN:
  - The counter increments every cycle, `stall` included.
  - At count = `DRAIN_CYCLES`-1 the next state is HALT.
  - A `flush` in DRAIN returns to RUN, clears the counter and loads `branch_target` into the PC (a branch already in ID redirects back into the program).
- HALT: absorbing until reset. `pc_keep`=1, `id_valid`=0, `flush` ignored.
- `halted` = (state==HALT), registered. It is 0 out of reset.
- Reset mid-DRAIN or in HALT: next cycle is RUN with all outputs at their reset values.

## Timing
- `pc_next` and `pc_keep` are combinational from the inputs and the state. There is no register between this block and the PC register.
- IF/ID fields have 1-cycle latency: the values sampled at edge N appear after edge N.
- Reset values:
  - `id_pc`=32'h00400000, `id_pc_plus4`=32'h00400004, `id_instr`=0, `id_valid`=0, `halted`=0.
  - `pc_next`=`pc_if`+4 and `pc_keep`=`stall` (state RUN, no flush).
- `halted` rises exactly `DRAIN_CYCLES` edges after the RUN→DRAIN edge, if there is no intervening flush.
- Simultaneous `stall`+`flush`: flush wins for both IF/ID and the PC.

## Structure
- Shared package `cpu_pkg`: `NOP_INSTR`, `RESET_PC`, `PC_LIMIT`, and the fetch state enum (RUN/DRAIN/HALT). The PC register reads the same constants.
- One sub-module, `if_id_reg`: the 4-field register with reset/flush/stall/load priority. FSM, counter and next-PC mux stay in the top level.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release. Required: `id_valid`=0, `id_instr`=0, `id_pc`=0x00400000, `halted`=0; `pc_next`=`pc_if`+4.
- Straight-line fetch: `pc_if`=0x00400008, `instr_if`=0x20080005. Required: next cycle `id_pc`=0x00400008, `id_pc_plus4`=0x0040000C, `id_instr`=0x20080005, `id_valid`=1.
- Stall: `stall`=1 for 3 cycles with changing `instr_if`. Required: IF/ID unchanged and `pc_keep`=1 throughout.
- Flush with stall: `stall`=1, `flush`=1, `branch_target`=0x00400020. Required: `pc_next`=0x00400020, `pc_keep`=0, next cycle `id_valid`=0 and `id_instr`=0.
- Drain: `pc_if`=0x00400060. Required: DRAIN entered, `pc_keep`=1, `halted`=1 after exactly 4 edges, `flush` then ignored.
- Flush in DRAIN: `flush` at drain cycle 1 with target 0x00400010. Required: back to RUN, `pc_next`=0x00400010, `halted` stays 0.
